sump2_event_filter: RTL and testbench

Input conditioning stage for the SUMP2 capture path. It sits directly upstream of the capture core's `events_din` bus in the capture clock domain. It takes the raw asynchronous event pins and applies, per channel:
- a two-flop synchronizer,
- an optional polarity inversion,
- a programmable glitch filter (a run-length debounce).

It also produces per-channel rise/fall strobes, an any-change strobe for RLE/trigger logic, and one saturating edge counter for bring-up diagnostics.

---
 rtl/sump2_event_filter_if.sv | 27 ++
 rtl/sump2_event_filter.sv | 88 ++++++++
 tb/tb_sump2_event_filter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sump2_event_filter_if.sv
// rtl/sump2_event_filter_if.sv - event pin / conditioned event bundle for the SUMP2 input filter
interface sump2_event_filter_if #(
  parameter int CH     = 24,
  parameter int FILT_W = 4,
  parameter int CNT_W  = 16
);
  logic [CH-1:0]     events_din;
  logic [CH-1:0]     invert_mask;
  logic [FILT_W-1:0] filt_len;
  logic [4:0]        cnt_sel;
  logic              cnt_clr;
  logic [CH-1:0]     events_dout;
  logic [CH-1:0]     edge_rise;
  logic [CH-1:0]     edge_fall;
  logic              change;
  logic [CNT_W-1:0]  edge_cnt;

  modport master (
    output events_din, invert_mask, filt_len, cnt_sel, cnt_clr,
    input  events_dout, edge_rise, edge_fall, change, edge_cnt
  );

  modport slave (
    input  events_din, invert_mask, filt_len, cnt_sel, cnt_clr,
    output events_dout, edge_rise, edge_fall, change, edge_cnt
  );
endinterface

// File: rtl/sump2_event_filter.sv
// rtl/sump2_event_filter.sv - synchronize, invert and run-length debounce SUMP2 event pins
// Also emits per-channel edge strobes, an any-change strobe and a saturating edge counter.
module sump2_event_filter #(
  parameter int CH     = 24,
  parameter int FILT_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset_l,
  sump2_event_filter_if.slave   bus
);
  localparam int unsigned CH_U = CH;

  logic [CH-1:0]     s1_q, s1_d;
  logic [CH-1:0]     s2_q, s2_d;
  logic [CH-1:0]     dout_q, dout_d;
  logic [CH-1:0]     rise_q, rise_d;
  logic [CH-1:0]     fall_q, fall_d;
  logic              change_q, change_d;
  logic [FILT_W-1:0] run_q [CH];
  logic [FILT_W-1:0] run_d [CH];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH-1:0]     cond;
  logic [CH-1:0]     edges_q;
  logic              sel_hit;

  // run[i] counts consecutive cycles the conditioned input disagrees with the output;
  // >= (not ==) lets a lowered filt_len release a pending channel immediately.
  always_comb begin
    s1_d   = bus.events_din;
    s2_d   = s1_q;
    cond   = s2_q ^ bus.invert_mask;
    dout_d = dout_q;
    for (int i = 0; i < CH; i++) begin
      run_d[i] = '0;
      if (cond[i] != dout_q[i]) begin
        if (run_q[i] >= bus.filt_len) begin
          dout_d[i] = cond[i];
        end else begin
          run_d[i] = run_q[i] + FILT_W'(1);
        end
      end
    end
    rise_d   = dout_d & ~dout_q;
    fall_d   = dout_q & ~dout_d;
    change_d = |(rise_d | fall_d);
  end

  assign edges_q = rise_q | fall_q;
  assign sel_hit = (32'(bus.cnt_sel) < CH_U) && edges_q[bus.cnt_sel];

  always_comb begin
    cnt_d = cnt_q;
    if (bus.cnt_clr) begin
      cnt_d = '0;
    end else if (sel_hit && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      s1_q     <= '0;
      s2_q     <= '0;
      dout_q   <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      change_q <= 1'b0;
      run_q    <= '{default: '0};
      cnt_q    <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      dout_q   <= dout_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      change_q <= change_d;
      run_q    <= run_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.events_dout = dout_q;
  assign bus.edge_rise   = rise_q;
  assign bus.edge_fall   = fall_q;
  assign bus.change      = change_q;
  assign bus.edge_cnt    = cnt_q;
endmodule

// File: tb/tb_sump2_event_filter.sv
// tb/tb_sump2_event_filter.sv - self-checking bench for sump2_event_filter
module tb_sump2_event_filter;
  localparam int CH     = 24;
  localparam int FILT_W = 4;
  localparam int CNT_W  = 16;
  localparam int VW     = 3*CH + 1 + CNT_W;

  logic clk = 1'b0;
  logic reset_l;
  always #5 clk = ~clk;

  sump2_event_filter_if #(.CH(CH), .FILT_W(FILT_W), .CNT_W(CNT_W)) bus ();
  sump2_event_filter #(.CH(CH), .FILT_W(FILT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_l(reset_l), .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [CH-1:0]    m_s1, m_s2, m_dout, m_rise, m_fall, m_cond, m_next, m_edges;
  logic             m_change;
  logic [CNT_W-1:0] m_cnt;
  logic [CH-1:0]    m_hist [16];

  // A channel adopts the conditioned value once the last flen+1 samples all oppose the output.
  function automatic logic [CH-1:0] settle(input logic [CH-1:0] c, input logic [CH-1:0] dout,
                                           input logic [CH-1:0] hist [16], input int flen);
    logic [CH-1:0] nd;
    nd = dout;
    for (int ch = 0; ch < CH; ch++) begin
      bit opp;
      opp = 1'b1;
      for (int k = 0; k <= flen; k++) begin
        logic s;
        s = (k == 0) ? c[ch] : hist[k-1][ch];
        if (s == dout[ch]) opp = 1'b0;
      end
      if (opp) nd[ch] = c[ch];
    end
    return nd;
  endfunction

  assign m_cond  = m_s2 ^ bus.invert_mask;
  assign m_edges = m_rise | m_fall;
  always_comb m_next = settle(m_cond, m_dout, m_hist, int'(bus.filt_len));

  always @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      m_s1 <= '0; m_s2 <= '0; m_dout <= '0; m_rise <= '0; m_fall <= '0;
      m_change <= 1'b0; m_cnt <= '0; m_hist <= '{default: '0};
    end else begin
      m_s1     <= bus.events_din;
      m_s2     <= m_s1;
      m_dout   <= m_next;
      m_rise   <= m_next & ~m_dout;
      m_fall   <= m_dout & ~m_next;
      m_change <= (m_next != m_dout);
      m_hist[0] <= m_cond;
      for (int k = 1; k < 16; k++) m_hist[k] <= m_hist[k-1];
      if (bus.cnt_clr) m_cnt <= '0;
      else if (int'(bus.cnt_sel) < CH && m_edges[bus.cnt_sel] && m_cnt != '1) m_cnt <= m_cnt + 1'b1;
    end
  end

  logic [VW-1:0] dut_vec, mdl_vec;
  assign dut_vec = {bus.events_dout, bus.edge_rise, bus.edge_fall, bus.change, bus.edge_cnt};
  assign mdl_vec = {m_dout, m_rise, m_fall, m_change, m_cnt};

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [FILT_W-1:0] flen, input logic [CH-1:0] inv);
    reset_l = 1'b0;
    bus.events_din = '0; bus.invert_mask = inv; bus.filt_len = flen;
    bus.cnt_sel = 5'd0; bus.cnt_clr = 1'b0;
    tick();
    reset_l = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(4'd0, '0);
    reset_l = 1'b0;
    tick();
    n_vec++;
    if (dut_vec !== '0) begin n_err++; $display("FAIL reset_hold got %h want 0", dut_vec); end
    reset_l = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_vec++;
      if (dut_vec !== '0) begin n_err++; $display("FAIL reset_release cyc %0d got %h want 0", k, dut_vec); end
    end
    for (int k = 0; k < 6; k++) begin
      bus.events_din[0] = ~bus.events_din[0];
      tick();
      n_vec++;
      if (dut_vec !== mdl_vec) begin n_err++; $display("FAIL reset_toggle cyc %0d got %h want %h", k, dut_vec, mdl_vec); end
    end
    #2 reset_l = 1'b0;
    #1;
    n_vec++;
    if (dut_vec !== '0) begin n_err++; $display("FAIL reset_async got %h want 0", dut_vec); end
    @(negedge clk);
    bus.events_din = '0;
    reset_l = 1'b1;
  endtask

  task automatic test_latency();
    do_reset(4'd0, '0);
    for (int k = 0; k < 4; k++) tick();
    bus.events_din[3] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_vec++;
      if ({bus.events_dout[3], bus.edge_rise[3], bus.change} !== {k >= 3, k == 3, k == 3}) begin
        n_err++;
        $display("FAIL lat_rise edge %0d got %b want %b", k,
                 {bus.events_dout[3], bus.edge_rise[3], bus.change}, {k >= 3, k == 3, k == 3});
      end
    end
    bus.events_din[3] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_vec++;
      if ({bus.events_dout[3], bus.edge_fall[3], bus.change} !== {k < 3, k == 3, k == 3}) begin
        n_err++;
        $display("FAIL lat_fall edge %0d got %b want %b", k,
                 {bus.events_dout[3], bus.edge_fall[3], bus.change}, {k < 3, k == 3, k == 3});
      end
    end
  endtask

  task automatic test_glitch();
    for (int len = 3; len <= 4; len++) begin
      int rises, falls, highs;
      rises = 0; falls = 0; highs = 0;
      do_reset(4'd3, '0);
      for (int k = 0; k < 6; k++) tick();
      bus.events_din[5] = 1'b1;
      for (int k = 0; k < 20; k++) begin
        if (k == len) bus.events_din[5] = 1'b0;
        tick();
        rises += int'(bus.edge_rise[5]);
        falls += int'(bus.edge_fall[5]);
        highs += int'(bus.events_dout[5]);
        n_vec++;
        if (dut_vec !== mdl_vec) begin n_err++; $display("FAIL glitch_model len %0d got %h want %h", len, dut_vec, mdl_vec); end
      end
      n_vec++;
      if (len == 3 && {rises, falls, highs} !== {32'd0, 32'd0, 32'd0}) begin
        n_err++; $display("FAIL glitch_reject got r%0d f%0d h%0d want 0 0 0", rises, falls, highs);
      end else if (len == 4 && {rises, falls, highs} !== {32'd1, 32'd1, 32'd4}) begin
        n_err++; $display("FAIL glitch_pass got r%0d f%0d h%0d want 1 1 4", rises, falls, highs);
      end
    end
  endtask

  task automatic test_filt_lower();
    do_reset(4'd10, '0);
    bus.events_din[1] = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    n_vec++;
    if (bus.events_dout[1] !== 1'b0) begin n_err++; $display("FAIL filt_pending got %b want 0", bus.events_dout[1]); end
    bus.filt_len = 4'd2;
    tick();
    n_vec++;
    if ({bus.events_dout[1], bus.edge_rise[1]} !== 2'b11) begin
      n_err++; $display("FAIL filt_lowered got %b want 11", {bus.events_dout[1], bus.edge_rise[1]});
    end
  endtask

  task automatic test_invert();
    int rises, falls, changes, both;
    rises = 0; falls = 0; changes = 0; both = 0;
    do_reset(4'd0, 24'h000001);
    for (int k = 0; k < 6; k++) begin
      tick();
      rises += int'(bus.edge_rise[0]);
      n_vec++;
      if (dut_vec !== mdl_vec) begin n_err++; $display("FAIL inv_model got %h want %h", dut_vec, mdl_vec); end
    end
    n_vec++;
    if (rises != 1 || bus.events_dout[0] !== 1'b1) begin
      n_err++; $display("FAIL inv_rise got rises %0d dout %b want 1 1", rises, bus.events_dout[0]);
    end
    bus.invert_mask = '0;
    for (int k = 0; k < 6; k++) begin
      tick();
      falls += int'(bus.edge_fall[0]);
    end
    n_vec++;
    if (falls != 1) begin n_err++; $display("FAIL inv_toggle got falls %0d want 1", falls); end
    bus.events_din[0] = 1'b1;
    bus.events_din[23] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      changes += int'(bus.change);
      both += int'(bus.edge_rise[0] & bus.edge_rise[23]);
    end
    n_vec++;
    if (changes != 1 || both != 1) begin
      n_err++; $display("FAIL simul got change %0d both %0d want 1 1", changes, both);
    end
  endtask

  task automatic test_counter();
    bit found;
    do_reset(4'd0, '0);
    bus.cnt_sel = 5'd2;
    for (int j = 0; j < 5; j++) begin
      bus.events_din[2] = ~bus.events_din[2];
      if (j < 3) bus.events_din[4] = ~bus.events_din[4];
      tick(); tick();
    end
    for (int k = 0; k < 4; k++) tick();
    n_vec++;
    if (bus.edge_cnt !== 16'd5) begin n_err++; $display("FAIL cnt_five got %0d want 5", bus.edge_cnt); end
    found = 1'b0;
    bus.events_din[2] = ~bus.events_din[2];
    for (int w = 0; w < 8 && !found; w++) begin
      tick();
      if (bus.edge_rise[2] | bus.edge_fall[2]) begin
        found = 1'b1;
        bus.cnt_clr = 1'b1;
        tick();
        bus.cnt_clr = 1'b0;
        n_vec++;
        if (bus.edge_cnt !== 16'd0) begin n_err++; $display("FAIL cnt_clr_edge got %0d want 0", bus.edge_cnt); end
      end
    end
    if (!found) begin n_vec++; n_err++; $display("FAIL cnt_clr_edge got no strobe want strobe"); end
    for (int j = 0; j < 3; j++) begin
      bus.events_din[2] = ~bus.events_din[2];
      tick(); tick();
    end
    for (int k = 0; k < 4; k++) tick();
    bus.cnt_sel = 5'd30;
    for (int j = 0; j < 6; j++) begin
      bus.events_din = ~bus.events_din;
      tick(); tick();
    end
    n_vec++;
    if (bus.edge_cnt !== 16'd3) begin n_err++; $display("FAIL cnt_sel_hold got %0d want 3", bus.edge_cnt); end
    bus.cnt_sel = 5'd2;
    for (int j = 0; j < 65540; j++) begin
      bus.events_din[2] = ~bus.events_din[2];
      tick();
      n_vec++;
      if (dut_vec !== mdl_vec) begin n_err++; $display("FAIL cnt_sat_model cyc %0d got %h want %h", j, dut_vec, mdl_vec); end
    end
    for (int k = 0; k < 4; k++) tick();
    n_vec++;
    if (bus.edge_cnt !== 16'hFFFF) begin n_err++; $display("FAIL cnt_saturate got %h want ffff", bus.edge_cnt); end
  endtask

  task automatic test_random();
    do_reset(4'($urandom_range(0, 15)), '0);
    for (int k = 0; k < 3000; k++) begin
      bus.events_din = bus.events_din ^ (CH'($urandom) & CH'($urandom) & CH'($urandom));
      if ($urandom_range(0, 199) == 0) bus.filt_len = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) bus.invert_mask = bus.invert_mask ^ (CH'(1) << $urandom_range(0, CH-1));
      if ($urandom_range(0, 63) == 0) bus.cnt_sel = 5'($urandom_range(0, 31));
      bus.cnt_clr = ($urandom_range(0, 49) == 0);
      tick();
      n_vec++;
      if (dut_vec !== mdl_vec) begin n_err++; $display("FAIL random cyc %0d got %h want %h", k, dut_vec, mdl_vec); end
    end
    bus.cnt_clr = 1'b0;
  endtask

  initial begin
    reset_l = 1'b0;
    bus.events_din = '0; bus.invert_mask = '0; bus.filt_len = '0;
    bus.cnt_sel = '0; bus.cnt_clr = 1'b0;
    @(negedge clk);
    test_reset();
    test_latency();
    test_glitch();
    test_filt_lower();
    test_invert();
    test_random();
    test_counter();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
